// File: rtl/m_mem_arbiter_pkg.sv
// Shared constants for the instruction/data memory arbiter: port identifiers
// and parameter defaults. Optional starvation guard is enabled by ARB_STARVE_GUARD_EN.
package m_mem_arbiter_pkg;

    typedef enum logic {
        ARB_PORT_I = 1'b0,
        ARB_PORT_D = 1'b1
    } arb_port_e;

    localparam int ARB_AW_DEF         = 11;
    localparam int ARB_DW_DEF         = 32;
    localparam int ARB_STARVE_MAX_DEF = 3;
    localparam int ARB_STALL_W        = 16;

    // Width needed to hold values 0..max_val, never less than one bit.
    function automatic int arb_cnt_width(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/m_arb_sat_cnt.sv
// Saturating up-counter with synchronous clear; clear takes precedence over increment.
module m_arb_sat_cnt #(
    parameter int W   = 16,
    parameter int MAX = 65535
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    localparam logic [W-1:0] CNT_MAX = W'(MAX);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/m_mem_arbiter.sv
// Two-port (fetch/data) arbiter in front of a single-ported synchronous memory.
// Data has priority; defining ARB_STARVE_GUARD_EN lets a starved fetch win after STARVE_MAX denials.
module m_mem_arbiter
    import m_mem_arbiter_pkg::*;
#(
    parameter int AW         = ARB_AW_DEF,
    parameter int DW         = ARB_DW_DEF,
    parameter int STARVE_MAX = ARB_STARVE_MAX_DEF
) (
    input  logic                   w_clk,
    input  logic                   w_rst_n,
    input  logic                   w_i_req,
    input  logic [AW-1:0]          w_i_addr,
    output logic                   w_i_gnt,
    output logic                   r_i_rvalid,
    output logic [DW-1:0]          w_i_rdata,
    input  logic                   w_d_req,
    input  logic                   w_d_we,
    input  logic [AW-1:0]          w_d_addr,
    input  logic [DW-1:0]          w_d_wdata,
    output logic                   w_d_gnt,
    output logic                   r_d_rvalid,
    output logic [DW-1:0]          w_d_rdata,
    output logic [AW-1:0]          w_m_addr,
    output logic                   w_m_we,
    output logic [DW-1:0]          w_m_din,
    input  logic [DW-1:0]          w_m_dout,
    output logic [ARB_STALL_W-1:0] r_stall_cnt
);

    logic      fetch_force;
    logic      fetch_denied;
    arb_port_e sel_port;
    logic      i_rvalid_q, i_rvalid_d;
    logic      d_rvalid_q, d_rvalid_d;

    assign fetch_denied = w_i_req && !w_i_gnt;

`ifdef ARB_STARVE_GUARD_EN
    localparam int SW = arb_cnt_width(STARVE_MAX);

    logic [SW-1:0] starve_cnt;

    m_arb_sat_cnt #(
        .W   (SW),
        .MAX (STARVE_MAX)
    ) u_starve_cnt (
        .clk_i  (w_clk),
        .rst_ni (w_rst_n),
        .clr_i  (!fetch_denied),
        .inc_i  (fetch_denied),
        .cnt_o  (starve_cnt)
    );

    assign fetch_force = w_i_req && (starve_cnt == SW'(STARVE_MAX));
`else
    assign fetch_force = 1'b0;
`endif

    // Grants are decided in the request cycle; reset masks both.
    always_comb begin
        w_i_gnt = 1'b0;
        w_d_gnt = 1'b0;
        if (w_rst_n) begin
            if (w_i_req && (fetch_force || !w_d_req)) begin
                w_i_gnt = 1'b1;
            end else if (w_d_req) begin
                w_d_gnt = 1'b1;
            end
        end
    end

    // With no grant the memory still sees the fetch address, keeping the mux idle-stable.
    assign sel_port = w_d_gnt ? ARB_PORT_D : ARB_PORT_I;
    assign w_m_addr = (sel_port == ARB_PORT_D) ? w_d_addr : w_i_addr;
    assign w_m_we   = w_d_gnt && w_d_we;
    assign w_m_din  = w_d_wdata;

    assign i_rvalid_d = w_i_gnt;
    assign d_rvalid_d = w_d_gnt && !w_d_we;

    always_ff @(posedge w_clk) begin
        if (!w_rst_n) begin
            i_rvalid_q <= 1'b0;
            d_rvalid_q <= 1'b0;
        end else begin
            i_rvalid_q <= i_rvalid_d;
            d_rvalid_q <= d_rvalid_d;
        end
    end

    assign r_i_rvalid = i_rvalid_q;
    assign r_d_rvalid = d_rvalid_q;
    assign w_i_rdata  = w_m_dout;
    assign w_d_rdata  = w_m_dout;

    m_arb_sat_cnt #(
        .W   (ARB_STALL_W),
        .MAX ((1 << ARB_STALL_W) - 1)
    ) u_stall_cnt (
        .clk_i  (w_clk),
        .rst_ni (w_rst_n),
        .clr_i  (1'b0),
        .inc_i  (fetch_denied),
        .cnt_o  (r_stall_cnt)
    );

endmodule

// File: doc/m_mem_arbiter.md
M_MEM_ARBITER -- requirements
Module: m_mem_arbiter

Interface
REQ-001 Parameter AW, default 11, word-address width (matches the 2048-word memory).
REQ-002 Parameter DW, default 32, data width.
REQ-003 Parameter STARVE_MAX, default 3, consecutive denied fetch cycles before fetch is forced to win.
REQ-004 w_clk  in  1  single clock; all state updates on posedge.
REQ-005 w_rst_n  in  1  reset, synchronous, active-low.
REQ-006 w_i_req  in  1  instruction-fetch read request.
REQ-007 w_i_addr  in  AW  fetch word address.
REQ-008 w_i_gnt  out  1  fetch granted this cycle.
REQ-009 r_i_rvalid  out  1  fetch read data valid on w_i_rdata.
REQ-010 w_i_rdata  out  DW  fetch read data.
REQ-011 w_d_req  in  1  data-port request (load or store).
REQ-012 w_d_we  in  1  data-port write enable; qualifies w_d_req.
REQ-013 w_d_addr  in  AW  data word address.
REQ-014 w_d_wdata  in  DW  store data.
REQ-015 w_d_gnt  out  1  data port granted this cycle.
REQ-016 r_d_rvalid  out  1  load data valid on w_d_rdata.
REQ-017 w_d_rdata  out  DW  load data.
REQ-018 w_m_addr  out  AW  shared memory address.
REQ-019 w_m_we  out  1  shared memory write enable.
REQ-020 w_m_din  out  DW  shared memory write data.
REQ-021 w_m_dout  in  DW  shared memory registered read data (one-cycle latency).
REQ-022 r_stall_cnt  out  16  saturating count of cycles with fetch denied.

Function
REQ-023 Grants SHALL be combinational in the request cycle, with at most one of w_i_gnt/w_d_gnt high per cycle.
REQ-024 Default priority: data over fetch; lone requester always granted.
REQ-025 Memory drive: the granted port's address, its we (fetch = 0) and w_d_wdata; with no grant, w_m_we = 0 and w_m_addr = w_i_addr.
REQ-026 r_i_rvalid SHALL equal the registered w_i_gnt, and r_d_rvalid SHALL equal the registered (w_d_gnt && !w_d_we), giving exactly one cycle of latency.
REQ-027 w_i_rdata and w_d_rdata SHALL both carry w_m_dout; the rvalid bits identify the owner.
REQ-028 Stores produce no rvalid; a load granted the cycle after a store to the same address returns the stored value.
REQ-029 r_stall_cnt SHALL increment on each cycle with w_i_req && !w_i_gnt, and hold at 16'hFFFF with no wrap.
REQ-030 A requester that drops req while denied loses nothing; the block holds no request queue, so requesters hold req until granted.

Reset
REQ-031 While w_rst_n = 0 at posedge: r_i_rvalid = 0, r_d_rvalid = 0, r_stall_cnt = 0, starvation counter = 0.
REQ-032 While w_rst_n = 0 the grants SHALL be forced to 0 and w_m_we forced to 0.
REQ-033 Reset asserted the cycle after a granted read SHALL clear that pending rvalid, so that no data is delivered.

Configuration
REQ-034 Macro ARB_STARVE_GUARD_EN; when defined, a counter of consecutive w_i_req && !w_i_gnt cycles is kept.
REQ-035 With ARB_STARVE_GUARD_EN, when that counter equals STARVE_MAX, fetch wins that cycle over data.
REQ-036 With ARB_STARVE_GUARD_EN, the counter clears on w_i_gnt or !w_i_req, and saturates at STARVE_MAX.
REQ-037 Without ARB_STARVE_GUARD_EN: strict data priority, no counter logic present.

Structure
REQ-038 A shared package SHALL hold the port-ID constants (ARB_PORT_I = 0, ARB_PORT_D = 1) and the defaults for AW, DW and STARVE_MAX.
REQ-039 The one sub-module SHALL be m_arb_sat_cnt, a parameterised saturating counter with synchronous clear, used for r_stall_cnt and the starvation counter.

Verification
REQ-040 Fetch-only read at addr 0x010 (mem = 0xDEADBEEF) -> w_i_gnt same cycle; next cycle r_i_rvalid = 1, w_i_rdata = 0xDEADBEEF.
REQ-041 Simultaneous fetch 0x020 and load 0x100 -> w_d_gnt = 1, w_i_gnt = 0, r_stall_cnt = 1.
REQ-042 Next cycle, fetch still requesting -> fetch granted, data returned via r_d_rvalid.
REQ-043 Store 0x055 = 0x12345678, then load 0x055 -> r_d_rvalid = 1 with 0x12345678; r_i_rvalid never set.
REQ-044 ARB_STARVE_GUARD_EN with data requesting continuously and fetch requesting -> fetch granted on the 4th cycle (STARVE_MAX = 3); without the macro, fetch is never granted and r_stall_cnt counts each cycle.
REQ-045 w_rst_n low the cycle after a granted load -> r_d_rvalid = 0 and r_stall_cnt = 0.
REQ-046 Force 70000 denied cycles -> r_stall_cnt = 0xFFFF.
